// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared types and constants for the two-requester adder arbiter.
// Contents: FSM state encoding (IDLE/ADD/RESP) and the default operand width.
// No ports; imported by adder_arbiter and adder_dp.
package adder_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // IDLE: waiting for a request; ADD: latched operands flowing through the adder;
  // RESP: result held for the granted requester until it is taken.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_dp.sv
// adder_dp: combinational WIDTH-bit adder with carry out, zero latency.
// Ports: a_i, b_i operands in; sum_o = (a+b) mod 2^WIDTH, carry_o = carry out of bit WIDTH-1.
// No handshake; the arbiter decides when the result is captured.
module adder_dp
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Extend both operands by one bit so the carry is kept rather than truncated.
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one adder; round-robin on ties, one operation in flight.
// Latency: operands accepted at edge T, result presented from the cycle after edge T+1 (3 cycles/op min).
// Backpressure: rspN_ready low holds RESP indefinitely; reqN_ready stays low outside IDLE.
// Ports: clk, rst (async, active-high); reqN_valid/a/b in, reqN_ready out;
//        rspN_valid/sum/carry out, rspN_ready in (N = 0,1); busy out (state != IDLE).
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,

  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_carry,
  input  logic             rsp0_ready,

  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_carry,
  input  logic             rsp1_ready,

  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             pick;     // requester IDLE would grant this cycle
  logic             accept;   // operand handshake on either requester
  logic             rsp_done; // result handshake on the granted requester

  adder_dp #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Arbitration: a lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last_grant_q;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  // FSM process 1: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM process 2: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = ADD;
      ADD:                   state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM process 3: outputs. Ready is masked by rst so nothing is offered during reset,
  // and response data is zeroed whenever its valid is low.
  always_comb begin
    req0_ready = (state_q == IDLE) && !rst && req0_valid && !pick;
    req1_ready = (state_q == IDLE) && !rst && req1_valid &&  pick;
    rsp0_valid = (state_q == RESP) && !grant_q;
    rsp1_valid = (state_q == RESP) &&  grant_q;
    rsp0_sum   = rsp0_valid ? sum_q   : '0;
    rsp0_carry = rsp0_valid ? carry_q : 1'b0;
    rsp1_sum   = rsp1_valid ? sum_q   : '0;
    rsp1_carry = rsp1_valid ? carry_q : 1'b0;
    busy       = (state_q != IDLE);
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  // Datapath next-state: latch operands and grant on accept, capture the adder in ADD,
  // and record who was served once the result is taken.
  always_comb begin
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      grant_d = pick;
      a_d     = pick ? req1_a : req0_a;
      b_d     = pick ? req1_b : req0_b;
    end
    if (state_q == ADD) begin
      sum_d   = add_sum;
      carry_d = add_carry;
    end
    if (rsp_done) begin
      last_grant_d = grant_q;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter (WIDTH = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected {carry,sum} and requester id are queued at operand handshake and popped at result handshake.
module tb_adder_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic         rsp0_carry, rsp1_carry;
  logic         rsp0_ready, rsp1_ready;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Entry: {requester id, carry, sum}
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_sum   (rsp0_sum),
    .rsp0_carry (rsp0_carry),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_sum   (rsp1_sum),
    .rsp1_carry (rsp1_carry),
    .rsp1_ready (rsp1_ready),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input int id, input logic [8:0] got);
    logic [9:0] e;
    if (sb_q.size() == 0) begin
      check("rsp_unexpected", 32'(id + 1), 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("rsp_id", 32'(id), 32'(e[9]));
      check("rsp_carry_sum", 32'(got), 32'(e[8:0]));
    end
  endtask

  // Monitor: invariants every cycle out of reset, plus scoreboard push/pop.
  always @(negedge clk) begin
    if (!rst) begin
      check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      check("one_rsp", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (!rsp0_valid) check("rsp0_zero", 32'({rsp0_carry, rsp0_sum}), 32'd0);
      if (!rsp1_valid) check("rsp1_zero", 32'({rsp1_carry, rsp1_sum}), 32'd0);
      if (req0_valid && req0_ready)
        sb_q.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}});
      if (req1_valid && req1_ready)
        sb_q.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}});
      if (rsp0_valid && rsp0_ready) pop_cmp(0, {rsp0_carry, rsp0_sum});
      if (rsp1_valid && rsp1_ready) pop_cmp(1, {rsp1_carry, rsp1_sum});
    end
  end

  task automatic set_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  // Leaves the caller on the falling edge where the ready was seen.
  task automatic wait_ready(input int id);
    int n = 0;
    @(negedge clk);
    while (((id == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check((id == 0) ? "wait_req0_ready" : "wait_req1_ready",
          32'((id == 0) ? req0_ready : req1_ready), 32'd1);
  endtask

  task automatic wait_rsp(input int id);
    int n = 0;
    @(negedge clk);
    while (((id == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check((id == 0) ? "wait_rsp0_valid" : "wait_rsp1_valid",
          32'((id == 0) ? rsp0_valid : rsp1_valid), 32'd1);
  endtask

  // Waits for busy to drop, checks nothing is outstanding, and returns just after a rising edge.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();
  endtask

  task automatic op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    set_req(id, 1'b1, a, b);
    wait_ready(id);
    tick();
    set_req(id, 1'b0, a, b);
    wait_idle();
  endtask

  // Both requesters valid together; 'first' is the requester that must win the tie.
  task automatic do_tie(input int first);
    set_req(0, 1'b1, 8'h01, 8'h02);
    set_req(1, 1'b1, 8'h10, 8'h20);
    @(negedge clk);
    check("tie_req0_ready", 32'(req0_ready), 32'(first == 0));
    check("tie_req1_ready", 32'(req1_ready), 32'(first == 1));
    tick();
    set_req(first, 1'b0, 8'h00, 8'h00);
    wait_ready(1 - first);
    tick();
    set_req(1 - first, 1'b0, 8'h00, 8'h00);
    wait_idle();
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state: outputs quiet, and a pending request is not offered ready.
    #1;
    set_req(0, 1'b1, 8'h55, 8'h66);
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      check("rst_rsp_data", 32'({rsp0_carry, rsp0_sum, rsp1_carry, rsp1_sum}), 32'd0);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
    end
    set_req(0, 1'b0, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // Ties after reset: requester 0 first, and again after requester 1 was served last.
    do_tie(0);
    do_tie(0);

    // Single requester 0, exact latency.
    set_req(0, 1'b1, 8'h12, 8'h34);
    @(negedge clk);
    check("lat_ready_T", 32'(req0_ready), 32'd1);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("lat_add_busy", 32'(busy), 32'd1);
    check("lat_add_rsp0", 32'(rsp0_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_rsp0_valid_T2", 32'(rsp0_valid), 32'd1);
    check("lat_rsp0_sum", 32'(rsp0_sum), 32'h46);
    check("lat_rsp0_carry", 32'(rsp0_carry), 32'd0);
    wait_idle();

    // Requester 0 was served last, so requester 1 now wins the tie.
    do_tie(1);

    // Overflow on requester 1.
    set_req(1, 1'b1, 8'hFF, 8'h01);
    wait_ready(1);
    tick();
    set_req(1, 1'b0, 8'h00, 8'h00);
    wait_rsp(1);
    check("ovf_sum", 32'(rsp1_sum), 32'h00);
    check("ovf_carry", 32'(rsp1_carry), 32'd1);
    wait_idle();

    // Stall in RESP with requester 1 waiting.
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 8'h20, 8'h30);
    wait_ready(0);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b1, 8'h05, 8'h06);
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("stall_rsp0_sum", 32'({rsp0_carry, rsp0_sum}), 32'h050);
      check("stall_req1_ready", 32'(req1_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    tick();
    rsp0_ready = 1'b1;
    wait_ready(1);
    tick();
    set_req(1, 1'b0, 8'h00, 8'h00);
    wait_idle();

    // Reset during ADD aborts the operation.
    set_req(0, 1'b1, 8'h0A, 8'h0B);
    wait_ready(0);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    tick();
    set_req(0, 1'b1, 8'h0C, 8'h0D);
    wait_ready(0);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00);
    wait_rsp(0);
    check("post_abort_sum", 32'({rsp0_carry, rsp0_sum}), 32'h019);
    wait_idle();

    // Random single-requester traffic through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
